spu_dual_issue_ctrl: RTL and testbench

//  Issue stage that feeds the RF/forwarding/even-odd pipe complex. Accepts an in-order decoded

---
 rtl/spu_dual_issue_ctrl.sv | 277 +++++++++++++++++++++++++++
 tb/tb_spu_dual_issue_ctrl.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spu_dual_issue_ctrl.sv
// spu_dual_issue_ctrl
// In-order dual-issue stage. Takes a decoded pair (slot0 older), steers each
// instruction to the even or odd pipe by unit_id[0], and holds back any
// instruction whose sources are still counting down in the per-register
// latency scoreboard. Issue registers load one cycle after the decision.
// Optional feature: define ISSUE_PERF_CNT_EN to add saturating perf counters
// (perf_dual_o, perf_single_o, perf_stall_o).
module spu_dual_issue_ctrl #(
  parameter int NUM_REGS = 128,
  parameter int LAT_W    = 4,
  localparam int REG_W   = $clog2(NUM_REGS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             s0_valid_i,
  input  logic [31:0]      s0_full_instr_i,
  input  logic [6:0]       s0_instr_id_i,
  input  logic [2:0]       s0_unit_id_i,
  input  logic [LAT_W-1:0] s0_latency_i,
  input  logic             s0_reg_wr_i,
  input  logic [REG_W-1:0] s0_reg_dst_i,
  input  logic [REG_W-1:0] s0_ra_addr_i,
  input  logic [REG_W-1:0] s0_rb_addr_i,
  input  logic [REG_W-1:0] s0_rc_addr_i,
  input  logic             s0_ra_use_i,
  input  logic             s0_rb_use_i,
  input  logic             s0_rc_use_i,
  input  logic             s1_valid_i,
  input  logic [31:0]      s1_full_instr_i,
  input  logic [6:0]       s1_instr_id_i,
  input  logic [2:0]       s1_unit_id_i,
  input  logic [LAT_W-1:0] s1_latency_i,
  input  logic             s1_reg_wr_i,
  input  logic [REG_W-1:0] s1_reg_dst_i,
  input  logic [REG_W-1:0] s1_ra_addr_i,
  input  logic [REG_W-1:0] s1_rb_addr_i,
  input  logic [REG_W-1:0] s1_rc_addr_i,
  input  logic             s1_ra_use_i,
  input  logic             s1_rb_use_i,
  input  logic             s1_rc_use_i,
  input  logic             flush_i,
  output logic             even_valid_o,
  output logic [31:0]      even_full_instr_o,
  output logic [6:0]       even_instr_id_o,
  output logic [2:0]       even_unit_id_o,
  output logic [LAT_W-1:0] even_latency_o,
  output logic             even_reg_wr_o,
  output logic [REG_W-1:0] even_reg_dst_o,
  output logic [REG_W-1:0] even_ra_addr_o,
  output logic [REG_W-1:0] even_rb_addr_o,
  output logic [REG_W-1:0] even_rc_addr_o,
  output logic             odd_valid_o,
  output logic [31:0]      odd_full_instr_o,
  output logic [6:0]       odd_instr_id_o,
  output logic [2:0]       odd_unit_id_o,
  output logic [LAT_W-1:0] odd_latency_o,
  output logic             odd_reg_wr_o,
  output logic [REG_W-1:0] odd_reg_dst_o,
  output logic [REG_W-1:0] odd_ra_addr_o,
  output logic [REG_W-1:0] odd_rb_addr_o,
  output logic [REG_W-1:0] odd_rc_addr_o
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]      perf_dual_o,
  output logic [31:0]      perf_single_o,
  output logic [31:0]      perf_stall_o
`endif
);

  // Fields carried into an issue register.
  typedef struct packed {
    logic [31:0]      full_instr;
    logic [6:0]       instr_id;
    logic [2:0]       unit_id;
    logic [LAT_W-1:0] latency;
    logic             reg_wr;
    logic [REG_W-1:0] reg_dst;
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rb;
    logic [REG_W-1:0] rc;
  } instr_t;

  // Source is blocked while its producer has not reached forwarding yet.
  function automatic logic src_blocked(input logic used, input logic [LAT_W-1:0] cnt);
    return used && (cnt != {LAT_W{1'b0}});
  endfunction

  // Address match qualified by the use bit.
  function automatic logic reg_hit(input logic used, input logic [REG_W-1:0] a,
                                   input logic [REG_W-1:0] b);
    return used && (a == b);
  endfunction

  instr_t           slot_s [2];
  logic [LAT_W-1:0] sb_q   [NUM_REGS];
  logic [LAT_W-1:0] sb_d   [NUM_REGS];
  logic [1:0]       done_q, done_d;
  logic             rdy0_s, rdy1_s, raw_s, waw_s;
  logic             act_s, done0_s, done1_s, iss0_s, iss1_s;
  instr_t           even_q, even_d, odd_q, odd_d;
  logic             even_vld_q, even_vld_d, odd_vld_q, odd_vld_d;

  // Gather the slot ports into a common record.
  always_comb begin
    slot_s[0].full_instr = s0_full_instr_i;
    slot_s[0].instr_id   = s0_instr_id_i;
    slot_s[0].unit_id    = s0_unit_id_i;
    slot_s[0].latency    = s0_latency_i;
    slot_s[0].reg_wr     = s0_reg_wr_i;
    slot_s[0].reg_dst    = s0_reg_dst_i;
    slot_s[0].ra         = s0_ra_addr_i;
    slot_s[0].rb         = s0_rb_addr_i;
    slot_s[0].rc         = s0_rc_addr_i;
    slot_s[1].full_instr = s1_full_instr_i;
    slot_s[1].instr_id   = s1_instr_id_i;
    slot_s[1].unit_id    = s1_unit_id_i;
    slot_s[1].latency    = s1_latency_i;
    slot_s[1].reg_wr     = s1_reg_wr_i;
    slot_s[1].reg_dst    = s1_reg_dst_i;
    slot_s[1].ra         = s1_ra_addr_i;
    slot_s[1].rb         = s1_rb_addr_i;
    slot_s[1].rc         = s1_rc_addr_i;
  end

  // Issue decision: source readiness, in-order rule, pipe conflict, intra-pair hazards.
  always_comb begin
    rdy0_s  = ~(src_blocked(s0_ra_use_i, sb_q[s0_ra_addr_i]) |
                src_blocked(s0_rb_use_i, sb_q[s0_rb_addr_i]) |
                src_blocked(s0_rc_use_i, sb_q[s0_rc_addr_i]));
    rdy1_s  = ~(src_blocked(s1_ra_use_i, sb_q[s1_ra_addr_i]) |
                src_blocked(s1_rb_use_i, sb_q[s1_rb_addr_i]) |
                src_blocked(s1_rc_use_i, sb_q[s1_rc_addr_i]));
    raw_s   = s0_reg_wr_i & (reg_hit(s1_ra_use_i, s1_ra_addr_i, s0_reg_dst_i) |
                             reg_hit(s1_rb_use_i, s1_rb_addr_i, s0_reg_dst_i) |
                             reg_hit(s1_rc_use_i, s1_rc_addr_i, s0_reg_dst_i));
    waw_s   = s0_reg_wr_i & reg_hit(s1_reg_wr_i, s1_reg_dst_i, s0_reg_dst_i);
    act_s   = in_valid_i & ~flush_i & ~rst_i;
    done0_s = ~s0_valid_i | done_q[0];
    done1_s = ~s1_valid_i | done_q[1];
    iss0_s  = act_s & s0_valid_i & ~done_q[0] & rdy0_s;
    iss1_s  = act_s & s1_valid_i & ~done_q[1] & rdy1_s & (done0_s | iss0_s) &
              ~(iss0_s & ((s0_unit_id_i[0] == s1_unit_id_i[0]) | raw_s | waw_s));
    in_ready_o = act_s & (done0_s | iss0_s) & (done1_s | iss1_s);
  end

  // Done-mask next state: cleared on flush or when the pair completes.
  always_comb begin
    done_d = done_q;
    if (flush_i) begin
      done_d = 2'b00;
    end else if (in_ready_o) begin
      done_d = 2'b00;
    end else begin
      done_d = done_q | {iss1_s, iss0_s};
    end
  end

  // Steer issued slots into the pipe selected by unit_id[0]; idle pipes get NOP.
  always_comb begin
    even_d     = '0;
    even_vld_d = 1'b0;
    odd_d      = '0;
    odd_vld_d  = 1'b0;
    if (iss0_s && !s0_unit_id_i[0]) begin
      even_d     = slot_s[0];
      even_vld_d = 1'b1;
    end else if (iss1_s && !s1_unit_id_i[0]) begin
      even_d     = slot_s[1];
      even_vld_d = 1'b1;
    end else begin
      even_d     = '0;
      even_vld_d = 1'b0;
    end
    if (iss0_s && s0_unit_id_i[0]) begin
      odd_d     = slot_s[0];
      odd_vld_d = 1'b1;
    end else if (iss1_s && s1_unit_id_i[0]) begin
      odd_d     = slot_s[1];
      odd_vld_d = 1'b1;
    end else begin
      odd_d     = '0;
      odd_vld_d = 1'b0;
    end
  end

  // Scoreboard next state: issuing writer loads its latency, else count down to zero.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (iss1_s && s1_reg_wr_i && (s1_reg_dst_i == REG_W'(r))) begin
        sb_d[r] = s1_latency_i;
      end else if (iss0_s && s0_reg_wr_i && (s0_reg_dst_i == REG_W'(r))) begin
        sb_d[r] = s0_latency_i;
      end else if (sb_q[r] != {LAT_W{1'b0}}) begin
        sb_d[r] = sb_q[r] - {{(LAT_W-1){1'b0}}, 1'b1};
      end else begin
        sb_d[r] = sb_q[r];
      end
    end
  end

  // State registers: scoreboard, done mask and both issue registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        sb_q[r] <= {LAT_W{1'b0}};
      end
      done_q     <= 2'b00;
      even_q     <= '0;
      even_vld_q <= 1'b0;
      odd_q      <= '0;
      odd_vld_q  <= 1'b0;
    end else begin
      sb_q       <= sb_d;
      done_q     <= done_d;
      even_q     <= even_d;
      even_vld_q <= even_vld_d;
      odd_q      <= odd_d;
      odd_vld_q  <= odd_vld_d;
    end
  end

  assign even_valid_o      = even_vld_q;
  assign even_full_instr_o = even_q.full_instr;
  assign even_instr_id_o   = even_q.instr_id;
  assign even_unit_id_o    = even_q.unit_id;
  assign even_latency_o    = even_q.latency;
  assign even_reg_wr_o     = even_q.reg_wr;
  assign even_reg_dst_o    = even_q.reg_dst;
  assign even_ra_addr_o    = even_q.ra;
  assign even_rb_addr_o    = even_q.rb;
  assign even_rc_addr_o    = even_q.rc;
  assign odd_valid_o       = odd_vld_q;
  assign odd_full_instr_o  = odd_q.full_instr;
  assign odd_instr_id_o    = odd_q.instr_id;
  assign odd_unit_id_o     = odd_q.unit_id;
  assign odd_latency_o     = odd_q.latency;
  assign odd_reg_wr_o      = odd_q.reg_wr;
  assign odd_reg_dst_o     = odd_q.reg_dst;
  assign odd_ra_addr_o     = odd_q.ra;
  assign odd_rb_addr_o     = odd_q.rb;
  assign odd_rc_addr_o     = odd_q.rc;

`ifdef ISSUE_PERF_CNT_EN
  // Saturating increment so long runs never wrap.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] perf_dual_q, perf_single_q, perf_stall_q;

  // Classify each non-flush cycle with a presented pair by number of issues.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_dual_q   <= 32'd0;
      perf_single_q <= 32'd0;
      perf_stall_q  <= 32'd0;
    end else if (in_valid_i && !flush_i) begin
      case ({iss1_s, iss0_s})
        2'b11:        perf_dual_q   <= sat_inc(perf_dual_q);
        2'b01, 2'b10: perf_single_q <= sat_inc(perf_single_q);
        default:      perf_stall_q  <= sat_inc(perf_stall_q);
      endcase
    end else begin
      perf_dual_q   <= perf_dual_q;
      perf_single_q <= perf_single_q;
      perf_stall_q  <= perf_stall_q;
    end
  end

  assign perf_dual_o   = perf_dual_q;
  assign perf_single_o = perf_single_q;
  assign perf_stall_o  = perf_stall_q;
`endif

endmodule

// File: tb/tb_spu_dual_issue_ctrl.sv
// Self-checking bench for spu_dual_issue_ctrl: directed scenarios plus a
// randomized run against a reference model that tracks, per register, the
// absolute cycle at which its result becomes forwardable.
module tb_spu_dual_issue_ctrl;

  typedef struct packed {
    logic        valid;
    logic [31:0] full;
    logic [6:0]  id;
    logic [2:0]  unit;
    logic [3:0]  lat;
    logic        wr;
    logic [6:0]  dst;
    logic [6:0]  ra;
    logic [6:0]  rb;
    logic [6:0]  rc;
    logic        ua;
    logic        ub;
    logic        uc;
  } slot_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic  rst, in_valid, flush, in_ready;
  slot_t sl [2];

  logic        even_valid, odd_valid, even_wr, odd_wr;
  logic [31:0] even_full, odd_full;
  logic [6:0]  even_id, odd_id, even_dst, odd_dst;
  logic [2:0]  even_unit, odd_unit;
  logic [3:0]  even_lat, odd_lat;
  logic [6:0]  even_ra, even_rb, even_rc, odd_ra, odd_rb, odd_rc;
`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] perf_dual, perf_single, perf_stall;
`endif

  logic [75:0] even_obs, odd_obs;
  assign even_obs = {even_valid, even_full, even_id, even_unit, even_lat, even_wr,
                     even_dst, even_ra, even_rb, even_rc};
  assign odd_obs  = {odd_valid, odd_full, odd_id, odd_unit, odd_lat, odd_wr,
                     odd_dst, odd_ra, odd_rb, odd_rc};

  int checks = 0;
  int errors = 0;

  // reference model state
  longint ready_at [128];
  longint cyc;
  int     ptr;

  spu_dual_issue_ctrl dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .s0_valid_i(sl[0].valid), .s0_full_instr_i(sl[0].full), .s0_instr_id_i(sl[0].id),
    .s0_unit_id_i(sl[0].unit), .s0_latency_i(sl[0].lat), .s0_reg_wr_i(sl[0].wr),
    .s0_reg_dst_i(sl[0].dst), .s0_ra_addr_i(sl[0].ra), .s0_rb_addr_i(sl[0].rb),
    .s0_rc_addr_i(sl[0].rc), .s0_ra_use_i(sl[0].ua), .s0_rb_use_i(sl[0].ub),
    .s0_rc_use_i(sl[0].uc),
    .s1_valid_i(sl[1].valid), .s1_full_instr_i(sl[1].full), .s1_instr_id_i(sl[1].id),
    .s1_unit_id_i(sl[1].unit), .s1_latency_i(sl[1].lat), .s1_reg_wr_i(sl[1].wr),
    .s1_reg_dst_i(sl[1].dst), .s1_ra_addr_i(sl[1].ra), .s1_rb_addr_i(sl[1].rb),
    .s1_rc_addr_i(sl[1].rc), .s1_ra_use_i(sl[1].ua), .s1_rb_use_i(sl[1].ub),
    .s1_rc_use_i(sl[1].uc),
    .flush_i(flush),
    .even_valid_o(even_valid), .even_full_instr_o(even_full), .even_instr_id_o(even_id),
    .even_unit_id_o(even_unit), .even_latency_o(even_lat), .even_reg_wr_o(even_wr),
    .even_reg_dst_o(even_dst), .even_ra_addr_o(even_ra), .even_rb_addr_o(even_rb),
    .even_rc_addr_o(even_rc),
    .odd_valid_o(odd_valid), .odd_full_instr_o(odd_full), .odd_instr_id_o(odd_id),
    .odd_unit_id_o(odd_unit), .odd_latency_o(odd_lat), .odd_reg_wr_o(odd_wr),
    .odd_reg_dst_o(odd_dst), .odd_ra_addr_o(odd_ra), .odd_rb_addr_o(odd_rb),
    .odd_rc_addr_o(odd_rc)
`ifdef ISSUE_PERF_CNT_EN
    , .perf_dual_o(perf_dual), .perf_single_o(perf_single), .perf_stall_o(perf_stall)
`endif
  );

  // Expected issue-register image for a slot.
  function automatic logic [75:0] img(input slot_t s);
    return {1'b1, s.full, s.id, s.unit, s.lat, s.wr, s.dst, s.ra, s.rb, s.rc};
  endfunction

  function automatic slot_t mk(input logic v, input logic [2:0] unit, input logic [3:0] lat,
                               input logic wr, input logic [6:0] dst,
                               input logic [6:0] ra, input logic ua,
                               input logic [6:0] rb, input logic ub);
    slot_t s;
    s.valid = v;     s.full = $urandom(); s.id = 7'($urandom_range(1, 127));
    s.unit = unit;   s.lat = lat;         s.wr = wr;  s.dst = dst;
    s.ra = ra;       s.ua = ua;           s.rb = rb;  s.ub = ub;
    s.rc = 7'($urandom_range(0, 127));    s.uc = 1'b0;
    return s;
  endfunction

  function automatic slot_t rnd_slot();
    slot_t s;
    s.valid = ($urandom_range(0, 3) != 0);
    s.full  = $urandom();
    s.id    = 7'($urandom_range(0, 127));
    s.unit  = 3'($urandom_range(0, 7));
    s.lat   = 4'($urandom_range(0, 4));
    s.wr    = 1'($urandom_range(0, 1));
    s.dst   = 7'($urandom_range(0, 7));
    s.ra    = 7'($urandom_range(0, 7));
    s.rb    = 7'($urandom_range(0, 7));
    s.rc    = 7'($urandom_range(0, 7));
    s.ua    = 1'($urandom_range(0, 1));
    s.ub    = 1'($urandom_range(0, 1));
    s.uc    = 1'($urandom_range(0, 1));
    return s;
  endfunction

  // A source set is forwardable once every used register has reached its ready cycle.
  function automatic bit srcs_ok(input slot_t s);
    return (!s.ua || ready_at[s.ra] <= cyc) && (!s.ub || ready_at[s.rb] <= cyc) &&
           (!s.uc || ready_at[s.rc] <= cyc);
  endfunction

  // Younger instruction reads or rewrites the older one's destination.
  function automatic bit conflict(input slot_t a, input slot_t b);
    return a.wr && ((b.ua && b.ra == a.dst) || (b.ub && b.rb == a.dst) ||
                    (b.uc && b.rc == a.dst) || (b.wr && b.dst == a.dst));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    flush    = 1'b0;
    sl[0]    = '0;
    sl[1]    = '0;
  endtask

  task automatic reset_model();
    for (int r = 0; r < 128; r++) ready_at[r] = 0;
    cyc = 0;
    ptr = 0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int nz;
    rst = 1'b1;
    idle();
    repeat (3) tick();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++;
    if (even_obs !== 76'd0) begin errors++; $display("FAIL reset_even got %h want 0", even_obs); end
    checks++;
    if (odd_obs !== 76'd0) begin errors++; $display("FAIL reset_odd got %h want 0", odd_obs); end
    nz = 0;
    for (int r = 0; r < 128; r++) if (dut.sb_q[r] !== 4'd0) nz++;
    checks++;
    if (nz != 0) begin errors++; $display("FAIL reset_sb nonzero entries %0d want 0", nz); end
    rst = 1'b0;
  endtask

  task automatic test_dual_issue();
    sl[0] = mk(1'b1, 3'd0, 4'd6, 1'b1, 7'd3, 7'd0, 1'b0, 7'd0, 1'b0);
    sl[1] = mk(1'b1, 3'd1, 4'd2, 1'b1, 7'd4, 7'd0, 1'b0, 7'd0, 1'b0);
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL dual_in_ready got %b want 1", in_ready); end
    tick();
    checks++;
    if (even_obs !== img(sl[0])) begin errors++; $display("FAIL dual_even got %h want %h", even_obs, img(sl[0])); end
    checks++;
    if (odd_obs !== img(sl[1])) begin errors++; $display("FAIL dual_odd got %h want %h", odd_obs, img(sl[1])); end
    checks++;
    if (dut.sb_q[3] !== 4'd6) begin errors++; $display("FAIL dual_sb3 got %0d want 6", dut.sb_q[3]); end
    idle();
    tick();
  endtask

  task automatic test_same_pipe();
    sl[0] = mk(1'b1, 3'd0, 4'd2, 1'b1, 7'd10, 7'd0, 1'b0, 7'd0, 1'b0);
    sl[1] = mk(1'b1, 3'd2, 4'd3, 1'b1, 7'd11, 7'd0, 1'b0, 7'd0, 1'b0);
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL same_rdy_n got %b want 0", in_ready); end
    tick();
    checks++;
    if (even_obs !== img(sl[0])) begin errors++; $display("FAIL same_even_n got %h want %h", even_obs, img(sl[0])); end
    checks++;
    if (odd_obs !== 76'd0) begin errors++; $display("FAIL same_odd_n got %h want 0", odd_obs); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL same_rdy_n1 got %b want 1", in_ready); end
    tick();
    checks++;
    if (even_obs !== img(sl[1])) begin errors++; $display("FAIL same_even_n1 got %h want %h", even_obs, img(sl[1])); end
    idle();
    tick();
  endtask

  task automatic test_raw_stall();
    int stalls;
    pulse_reset();
    sl[0] = mk(1'b1, 3'd0, 4'd6, 1'b1, 7'd5, 7'd0, 1'b0, 7'd0, 1'b0);
    sl[1] = mk(1'b0, 3'd0, 4'd0, 1'b0, 7'd0, 7'd0, 1'b0, 7'd0, 1'b0);
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_first_rdy got %b want 1", in_ready); end
    tick();
    sl[0] = mk(1'b1, 3'd1, 4'd1, 1'b1, 7'd6, 7'd5, 1'b1, 7'd0, 1'b0);
    #1;
    stalls = 0;
    while (!in_ready && stalls < 20) begin
      checks++;
      if (dut.sb_q[5] !== 4'(6 - stalls)) begin
        errors++; $display("FAIL raw_sb5 got %0d want %0d", dut.sb_q[5], 6 - stalls);
      end
      tick();
      stalls++;
      #1;
    end
    checks++;
    if (stalls != 6) begin errors++; $display("FAIL raw_stall_cycles got %0d want 6", stalls); end
    tick();
    checks++;
    if (odd_obs !== img(sl[0])) begin errors++; $display("FAIL raw_odd got %h want %h", odd_obs, img(sl[0])); end
`ifdef ISSUE_PERF_CNT_EN
    checks++;
    if (perf_stall !== 32'd6) begin errors++; $display("FAIL perf_stall got %0d want 6", perf_stall); end
    checks++;
    if (perf_single !== 32'd2) begin errors++; $display("FAIL perf_single got %0d want 2", perf_single); end
    checks++;
    if (perf_dual !== 32'd0) begin errors++; $display("FAIL perf_dual got %0d want 0", perf_dual); end
`endif
    idle();
    tick();
  endtask

  task automatic test_intra_pair_raw();
    int waits;
    sl[0] = mk(1'b1, 3'd0, 4'd3, 1'b1, 7'd20, 7'd0, 1'b0, 7'd0, 1'b0);
    sl[1] = mk(1'b1, 3'd1, 4'd1, 1'b1, 7'd21, 7'd0, 1'b0, 7'd20, 1'b1);
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL intra_rdy got %b want 0", in_ready); end
    tick();
    checks++;
    if (even_obs !== img(sl[0])) begin errors++; $display("FAIL intra_even got %h want %h", even_obs, img(sl[0])); end
    checks++;
    if (odd_obs !== 76'd0) begin errors++; $display("FAIL intra_odd_hold got %h want 0", odd_obs); end
    checks++;
    if (dut.sb_q[20] !== 4'd3) begin errors++; $display("FAIL intra_sb20 got %0d want 3", dut.sb_q[20]); end
    waits = 0;
    while (!in_ready && waits < 20) begin
      tick();
      waits++;
      #1;
    end
    checks++;
    if (waits != 3) begin errors++; $display("FAIL intra_wait got %0d want 3", waits); end
    tick();
    checks++;
    if (odd_obs !== img(sl[1])) begin errors++; $display("FAIL intra_odd got %h want %h", odd_obs, img(sl[1])); end
    idle();
    tick();
  endtask

  task automatic test_flush();
    sl[0] = mk(1'b1, 3'd0, 4'd5, 1'b1, 7'd12, 7'd0, 1'b0, 7'd0, 1'b0);
    sl[1] = mk(1'b1, 3'd2, 4'd1, 1'b1, 7'd13, 7'd0, 1'b0, 7'd0, 1'b0);
    in_valid = 1'b1;
    tick();
    checks++;
    if (even_obs !== img(sl[0])) begin errors++; $display("FAIL flush_pre_even got %h want %h", even_obs, img(sl[0])); end
    flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_rdy got %b want 0", in_ready); end
    tick();
    checks++;
    if (even_obs !== 76'd0) begin errors++; $display("FAIL flush_even got %h want 0", even_obs); end
    checks++;
    if (odd_obs !== 76'd0) begin errors++; $display("FAIL flush_odd got %h want 0", odd_obs); end
    checks++;
    if (dut.sb_q[12] !== 4'd4) begin errors++; $display("FAIL flush_sb12 got %0d want 4", dut.sb_q[12]); end
    flush = 1'b0;
    in_valid = 1'b0;
    tick();
    checks++;
    if (even_obs !== 76'd0) begin errors++; $display("FAIL flush_after_even got %h want 0", even_obs); end
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_repres_rdy got %b want 0", in_ready); end
    tick();
    checks++;
    if (even_obs !== img(sl[0])) begin errors++; $display("FAIL flush_repres_even got %h want %h", even_obs, img(sl[0])); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_repres_rdy1 got %b want 1", in_ready); end
    tick();
    checks++;
    if (even_obs !== img(sl[1])) begin errors++; $display("FAIL flush_repres_even1 got %h want %h", even_obs, img(sl[1])); end
    idle();
    tick();
  endtask

  task automatic test_random();
    bit          need_new, rst_now, flush_now, exp_ready, any, stop;
    bit          iss [2];
    int          k;
    logic [75:0] exp_even, exp_odd;
    pulse_reset();
    reset_model();
    need_new = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rst_now   = (i % 900 == 899);
      flush_now = ($urandom_range(0, 99) < 3);
      if (need_new) begin
        sl[0] = rnd_slot();
        sl[1] = rnd_slot();
        need_new = 1'b0;
      end
      in_valid = ($urandom_range(0, 99) < 85);
      rst      = rst_now;
      flush    = flush_now;
      #1;
      exp_ready = 1'b0;
      exp_even  = 76'd0;
      exp_odd   = 76'd0;
      iss[0] = 1'b0;
      iss[1] = 1'b0;
      if (!rst_now && !flush_now && in_valid) begin
        k = ptr; any = 1'b0; stop = 1'b0;
        while (k < 2 && !stop) begin
          if (!sl[k].valid) k++;
          else if (srcs_ok(sl[k]) &&
                   !(any && (sl[k].unit[0] == sl[0].unit[0] || conflict(sl[0], sl[k])))) begin
            iss[k] = 1'b1; any = 1'b1; k++;
          end else stop = 1'b1;
        end
        exp_ready = (k == 2);
        ptr = exp_ready ? 0 : k;
        for (int n = 0; n < 2; n++) begin
          if (iss[n]) begin
            if (sl[n].unit[0]) exp_odd = img(sl[n]);
            else exp_even = img(sl[n]);
          end
        end
      end
      checks++;
      if (in_ready !== exp_ready) begin
        errors++; $display("FAIL rnd_in_ready cyc %0d got %b want %b", i, in_ready, exp_ready);
      end
      tick();
      checks++;
      if (even_obs !== exp_even) begin
        errors++; $display("FAIL rnd_even cyc %0d got %h want %h", i, even_obs, exp_even);
      end
      checks++;
      if (odd_obs !== exp_odd) begin
        errors++; $display("FAIL rnd_odd cyc %0d got %h want %h", i, odd_obs, exp_odd);
      end
      if (rst_now) begin
        reset_model();
        need_new = 1'b1;
      end else begin
        for (int n = 0; n < 2; n++)
          if (iss[n] && sl[n].wr) ready_at[sl[n].dst] = cyc + 1 + longint'(sl[n].lat);
        cyc++;
        if (flush_now) begin
          ptr = 0;
          need_new = 1'b1;
        end
        if (exp_ready) need_new = 1'b1;
      end
    end
    rst = 1'b0;
    idle();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_dual_issue();
    test_same_pipe();
    test_raw_stall();
    test_intra_pair_raw();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout after %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
